mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Initiator side of the pipelined MAC interface: accepts a stream of signed
//  22-bit operand pairs, drives a 3-cycle MAC datapath and returns its 48-bit
//  sum_out as sum_in, so a back-to-back dot product runs at one pair/cycle.
//  Uses MAC_LAT interleaved partial-sum lanes, reduces them at vector end and
//  presents one 48-bit dot product per vector on a valid/ready output.
// PARAMETERS
//  DW      22  operand width (signed), must match the MAC data_in_a/b width
//  SW      48  accumulator width (signed), must match the MAC sum_in/sum_out width
//  MAC_LAT 3   MAC issue-to-o_valid latency in cycles = number of partial-sum lanes
//  CW      16  element-count width
// PORTS
//  clk         in  1   clock
//  rst         in  1   synchronous active-high reset
//  s_valid     in  1   operand pair valid
//  s_ready     out 1   sequencer accepts a pair (handshake = s_valid & s_ready)
//  s_a         in  DW  signed operand a
//  s_b         in  DW  signed operand b
//  s_last      in  1   pair is the final element of the vector
//  mac_i_valid out 1   to MAC i_valid
//  mac_a       out DW  to MAC data_in_a
//  mac_b       out DW  to MAC data_in_b
//  mac_sum_in  out SW  to MAC sum_in
//  mac_o_valid in  1   from MAC o_valid
//  mac_sum_out in  SW  from MAC sum_out
//  m_valid     out 1   dot product valid
//  m_ready     in  1   consumer accepts the result
//  m_dot       out SW  signed dot product
//  m_count     out CW  element count of the vector
//  err         out 1   sticky: mac_o_valid seen with nothing in flight
// BEHAVIOUR
//  Reset: every output is 0. Lanes, the in-flight counter and the element counter are cleared. FSM -> ACCUM.
//  FSM: ACCUM -(s_last handshake)-> DRAIN -(in-flight reaches 0)-> REDUCE -(1 cycle)-> OUT -(m_valid & m_ready)-> ACCUM.
//  s_ready = 1 only in ACCUM.
//  Issue is combinational:
//  - mac_i_valid = s_valid & s_ready.
//  - mac_a and mac_b pass s_a and s_b through.
//  Lane selection:
//  - Lane index = element count mod MAC_LAT; it advances only on a handshake.
//  - A tag shift register (MAC_LAT deep) records the lane of each issue; the tag of a returning result is aligned to mac_o_valid.
//  mac_sum_in, in priority order:
//  - 0 if this is the lane's first element of the vector.
//  - else mac_sum_out if mac_o_valid and the returning tag equals the issuing lane (same-cycle bypass).
//  - else the lane register.
//  On mac_o_valid, mac_sum_out is written to the tagged lane register.
//  - A lane's previous element is always issued >= MAC_LAT cycles earlier, so input gaps need no stall.
//  In-flight counter (0..MAC_LAT): +1 on issue, -1 on mac_o_valid; both in the same cycle leaves it unchanged.
//  If mac_o_valid arrives with in-flight = 0: ignore it and set err (cleared only by rst).
//  REDUCE: m_dot <= sum of all lane registers, SW-bit two's-complement wrap; lanes that were never used contribute 0.
//  Latency: with s_last handshaken in cycle T and a MAC_LAT=3 MAC, m_valid = 1 in cycle T+5. This holds for a vector of length 1 as well.
//  OUT:
//  - m_valid holds, with m_dot and m_count stable, until m_ready.
//  - On acceptance, the lanes and counters clear and s_ready = 1 in the next cycle.
//  m_count saturates at 2^CW-1. Accumulation wraps at SW bits, with no overflow flag.
//  rst mid-vector or mid-OUT aborts the vector: all outputs go to 0, the partial result is discarded, and the next vector starts clean.
// TESTING
//  a=[1,2,3,4], b=[5,6,7,8], continuous, m_ready=1 -> m_dot=70, m_count=4, m_valid exactly 5 cycles after the last beat.
//  N=1: a=-3, b=7 -> m_dot=48'hFFFF_FFFF_FFEB (-21), m_count=1.
//  Vector as in test 1 with 1-3 idle cycles between beats -> m_dot=70; mac_sum_in uses the bypass or the lane register correctly.
//  m_ready=0 for 10 cycles -> m_valid, m_dot and m_count stable and s_ready=0; the next vector a=b=[2,2] gives 8.
//  Four beats of a=b=-2^21 -> m_dot=2^44 (48'h1000_0000_0000); 8-beat random vectors match the reference model.
//  rst after 2 beats -> all outputs 0; the following [1..4]x[5..8] gives 70. Injected mac_o_valid at idle -> err=1.

Source files
------------

// File: rtl/mac_dot_if.sv
// mac_dot_if
//   Bundles the three buses of the dot-product sequencer:
//   - operand stream in  : s_valid, s_ready, s_a, s_b, s_last
//   - MAC datapath link  : mac_i_valid, mac_a, mac_b, mac_sum_in (to MAC),
//                          mac_o_valid, mac_sum_out (from MAC)
//   - result stream out  : m_valid, m_ready, m_dot, m_count, plus sticky err
//   master = sequencer view, slave = environment (source, MAC, consumer) view.
interface mac_dot_if #(
    parameter int DW = 22,
    parameter int SW = 48,
    parameter int CW = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_a;
    logic signed [DW-1:0] s_b;
    logic                 s_last;
    logic                 mac_i_valid;
    logic signed [DW-1:0] mac_a;
    logic signed [DW-1:0] mac_b;
    logic signed [SW-1:0] mac_sum_in;
    logic                 mac_o_valid;
    logic signed [SW-1:0] mac_sum_out;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [SW-1:0] m_dot;
    logic [CW-1:0]        m_count;
    logic                 err;

    modport master (
        input  s_valid, s_a, s_b, s_last, mac_o_valid, mac_sum_out, m_ready,
        output s_ready, mac_i_valid, mac_a, mac_b, mac_sum_in,
               m_valid, m_dot, m_count, err
    );

    modport slave (
        output s_valid, s_a, s_b, s_last, mac_o_valid, mac_sum_out, m_ready,
        input  s_ready, mac_i_valid, mac_a, mac_b, mac_sum_in,
               m_valid, m_dot, m_count, err
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Feeds a fixed-latency MAC with one signed operand pair per cycle and
//   closes the accumulation loop through MAC_LAT interleaved partial-sum
//   lanes, so back-to-back pairs never wait for the previous sum. At vector
//   end the lanes are drained, summed and presented as one dot product.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : mac_dot_if.master (operand stream, MAC link, result stream, err)
module mac_dot_sequencer #(
    parameter int DW      = 22,
    parameter int SW      = 48,
    parameter int MAC_LAT = 3,
    parameter int CW      = 16
) (
    input logic      clk,
    input logic      rst,
    mac_dot_if.master bus
);
    localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int FW = $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, REDUCE, OUT} state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MAC_LAT-1:0]   used_q, used_d;
    logic signed [SW-1:0] acc_q [MAC_LAT];
    logic signed [SW-1:0] acc_d [MAC_LAT];
    logic [LW-1:0]        tag_q [MAC_LAT];
    logic [LW-1:0]        tag_d [MAC_LAT];
    logic [FW-1:0]        infl_q, infl_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic signed [SW-1:0] m_dot_q, m_dot_d;
    logic [CW-1:0]        m_count_q, m_count_d;
    logic                 err_q, err_d;

    logic                 hs;
    logic                 ret_ok;
    logic [LW-1:0]        ret_tag;
    logic signed [SW-1:0] sum_in;
    logic signed [SW-1:0] red;

    // Element count saturates instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LW-1:0] lane_next(input logic [LW-1:0] l);
        return (l == LW'(MAC_LAT - 1)) ? '0 : l + 1'b1;
    endfunction

    assign hs      = bus.s_valid & s_ready_q;
    // A return with nothing in flight is spurious and must not touch a lane.
    assign ret_ok  = bus.mac_o_valid && (infl_q != '0);
    // The tag at the end of the shift register lines up with mac_o_valid.
    assign ret_tag = tag_q[MAC_LAT-1];

    assign bus.s_ready     = s_ready_q;
    assign bus.mac_i_valid = hs;
    assign bus.mac_a       = DW'(bus.s_a);
    assign bus.mac_b       = DW'(bus.s_b);
    assign bus.mac_sum_in  = sum_in;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_dot       = m_dot_q;
    assign bus.m_count     = m_count_q;
    assign bus.err         = err_q;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        used_d    = used_q;
        acc_d     = acc_q;
        infl_d    = infl_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_dot_d   = m_dot_q;
        m_count_d = m_count_q;
        err_d     = err_q;

        // Lane feedback: first element starts from 0; if the lane's previous
        // result returns this very cycle it is bypassed, else read the lane.
        sum_in = '0;
        if (used_q[lane_q]) begin
            if (ret_ok && (ret_tag == lane_q))
                sum_in = bus.mac_sum_out;
            else
                sum_in = acc_q[lane_q];
        end

        tag_d[0] = lane_q;
        for (int k = 1; k < MAC_LAT; k++)
            tag_d[k] = tag_q[k-1];

        if (ret_ok)
            acc_d[ret_tag] = bus.mac_sum_out;

        if (hs) begin
            used_d[lane_q] = 1'b1;
            lane_d         = lane_next(lane_q);
            cnt_d          = sat_inc(cnt_q);
        end

        case ({hs, ret_ok})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase

        if (bus.mac_o_valid && (infl_q == '0))
            err_d = 1'b1;

        // Unused lanes are masked so they contribute 0 to the reduction.
        red = '0;
        for (int k = 0; k < MAC_LAT; k++)
            if (used_q[k])
                red = red + acc_q[k];

        case (state_q)
            ACCUM: begin
                s_ready_d = 1'b1;
                if (hs && bus.s_last) begin
                    s_ready_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the last result lands in its lane.
                if (infl_d == '0)
                    state_d = REDUCE;
            end
            REDUCE: begin
                m_dot_d   = red;
                m_count_d = cnt_q;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    lane_d    = '0;
                    cnt_d     = '0;
                    used_d    = '0;
                    for (int k = 0; k < MAC_LAT; k++)
                        acc_d[k] = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            lane_q    <= '0;
            cnt_q     <= '0;
            used_q    <= '0;
            infl_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_dot_q   <= '0;
            m_count_q <= '0;
            err_q     <= 1'b0;
            for (int k = 0; k < MAC_LAT; k++) begin
                acc_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            used_q    <= used_d;
            infl_q    <= infl_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_dot_q   <= m_dot_d;
            m_count_q <= m_count_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            tag_q     <= tag_d;
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer
//   Drives mac_dot_sequencer with a 3-cycle MAC model closing the loop
//   (sum_out = sum_in + a*b), and checks dot products against a scoreboard.
module tb_mac_dot_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_dot_if #(.DW(22), .SW(48), .CW(16)) bus ();

    mac_dot_sequencer #(.DW(22), .SW(48), .MAC_LAT(3), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [47:0] dot;
        logic [15:0]        cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t_last      = 0;
    logic inj         = 1'b0;

    logic signed [21:0] va [16];
    logic signed [21:0] vb [16];

    // MAC model: three register stages, cleared by rst.
    logic [2:0]         mv;
    logic signed [47:0] ms [3];

    function automatic logic signed [47:0] mul(input logic signed [21:0] a,
                                               input logic signed [21:0] b);
        logic signed [47:0] x;
        logic signed [47:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mv <= '0;
        end else begin
            mv    <= {mv[1:0], bus.mac_i_valid};
            ms[0] <= bus.mac_sum_in + mul(bus.mac_a, bus.mac_b);
            ms[1] <= ms[0];
            ms[2] <= ms[1];
        end
    end

    assign bus.mac_o_valid = mv[2] | inj;
    assign bus.mac_sum_out = ms[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_s_ready"},    48'(bus.s_ready),     48'd0);
        check({tag, "_mac_i_vld"},  48'(bus.mac_i_valid), 48'd0);
        check({tag, "_mac_sum_in"}, bus.mac_sum_in,       48'd0);
        check({tag, "_m_valid"},    48'(bus.m_valid),     48'd0);
        check({tag, "_m_dot"},      bus.m_dot,            48'd0);
        check({tag, "_m_count"},    48'(bus.m_count),     48'd0);
        check({tag, "_err"},        48'(bus.err),         48'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 idle 1..3 cycles, 2 random 0..2 idle cycles.
    // abort_at >= 0 stops before that beat and pushes no expectation.
    task automatic send_vec(input int n, input int gap_mode, input int abort_at);
        exp_t e;
        int   k;
        int   g;
        e.dot = '0;
        for (int i = 0; i < n; i++)
            e.dot = e.dot + mul(va[i], vb[i]);
        e.cnt = 16'(n);
        if (abort_at < 0)
            sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at)
                return;
            bus.s_valid = 1'b1;
            bus.s_a     = va[i];
            bus.s_b     = vb[i];
            bus.s_last  = (i == n - 1);
            k = 0;
            while (!bus.s_ready && k < 100) begin
                tick();
                k++;
            end
            if (k == 100)
                check("s_ready_timeout", 48'd0, 48'd1);
            t_last = cyc;
            tick();
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            if (i < n - 1) begin
                g = (gap_mode == 1) ? 1 + (i % 3) :
                    (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (g) tick();
            end
        end
    endtask

    task automatic get_result(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.m_valid && k < 200) begin
            tick();
            k++;
        end
        if (k == 200) begin
            check({tag, "_m_valid_timeout"}, 48'd0, 48'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_result"}, 48'd1, 48'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_m_dot"},   bus.m_dot,          e.dot);
        check({tag, "_m_count"}, 48'(bus.m_count),   48'(e.cnt));
        check({tag, "_latency"}, 48'(cyc - t_last),  48'd5);
        if (bus.m_ready)
            tick();
    endtask

    task automatic load_1234_5678();
        for (int i = 0; i < 4; i++) begin
            va[i] = 22'(i + 1);
            vb[i] = 22'(i + 5);
        end
    endtask

    initial begin
        logic signed [47:0] big;
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();
        check("post_reset_s_ready", 48'(bus.s_ready), 48'd1);

        // Basic vector, continuous
        load_1234_5678();
        send_vec(4, 0, -1);
        get_result("basic");

        // Single-element vector
        va[0] = -22'sd3;
        vb[0] = 22'sd7;
        send_vec(1, 0, -1);
        get_result("n1");

        // Idle gaps between beats
        load_1234_5678();
        send_vec(4, 1, -1);
        get_result("gaps");

        // Consumer back-pressure
        bus.m_ready = 1'b0;
        load_1234_5678();
        send_vec(4, 0, -1);
        get_result("stall");
        for (int i = 0; i < 10; i++) begin
            check("stall_m_valid", 48'(bus.m_valid), 48'd1);
            check("stall_m_dot",   bus.m_dot,        48'd70);
            check("stall_m_count", 48'(bus.m_count), 48'd4);
            check("stall_s_ready", 48'(bus.s_ready), 48'd0);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        check("accept_m_valid", 48'(bus.m_valid), 48'd0);
        check("accept_s_ready", 48'(bus.s_ready), 48'd1);
        va[0] = 22'sd2; va[1] = 22'sd2;
        vb[0] = 22'sd2; vb[1] = 22'sd2;
        send_vec(2, 0, -1);
        get_result("after_stall");

        // Most negative operands
        for (int i = 0; i < 4; i++) begin
            va[i] = 22'h20_0000;
            vb[i] = 22'h20_0000;
        end
        send_vec(4, 0, -1);
        k_wait_big: begin
            int k;
            k = 0;
            while (!bus.m_valid && k < 50) begin
                tick();
                k++;
            end
        end
        big = 48'h1000_0000_0000;
        check("big_const", bus.m_dot, big);
        get_result("big");

        // Random 8-beat vectors
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) begin
                va[i] = 22'($urandom);
                vb[i] = 22'($urandom);
            end
            send_vec(8, (v == 0) ? 0 : 2, -1);
            get_result("rand");
        end

        // Reset mid-vector
        load_1234_5678();
        send_vec(4, 0, 2);
        bus.s_a = '0;
        bus.s_b = '0;
        rst = 1'b1;
        tick();
        check_zero_outputs("mid_rst");
        rst = 1'b0;
        tick();
        send_vec(4, 0, -1);
        get_result("post_rst");

        // Spurious MAC return while idle
        repeat (2) tick();
        check("err_before", 48'(bus.err), 48'd0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        check("err_set",    48'(bus.err),     48'd1);
        tick();
        check("err_sticky", 48'(bus.err),     48'd1);
        check("err_no_out", 48'(bus.m_valid), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
